// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port SRAM arbiter for MIPS fetch and data requesters
//
// Purpose: grants one of the fetch/data requesters per cycle, applies the
// kseg0/kseg1 -> physical mapping and drives the SRAM. It then steers the
// 1-cycle read data back to the requester that issued the read.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_req/inst_addr           fetch read request (inst_gnt accepts it)
//   inst_rvalid/inst_rdata       fetch read response
//   data_req/data_wen/data_addr/data_wdata   data request (wen 0 = read)
//   data_gnt                     data request accepted
//   data_rvalid/data_rdata       data read response
//   sram_en/sram_wen/sram_addr/sram_wdata/sram_rdata   SRAM port

module sram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  owner_t resp_owner;
  logic   force_inst;

  // kseg0 (0x8..0x9) and kseg1 (0xA..0xB) both have bits [31:30] == 2'b10;
  // both windows fold onto the low 512 MB of physical space.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [ADDR_W-1:0] va);
    if (va[31:30] == 2'b10) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  // Data has priority unless the starvation guard is forcing fetch.
  assign inst_gnt = inst_req && (!data_req || force_inst);
  assign data_gnt = data_req && !inst_gnt;

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_en   = 1'b1;
      sram_addr = phys_addr(inst_addr);
    end else if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = phys_addr(data_addr);
      sram_wdata = data_wdata;
    end
  end

  // Reloaded every cycle, so a response is tagged for exactly one cycle;
  // writes leave it NONE because the SRAM returns nothing useful for them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_owner <= OWN_NONE;
    end else if (inst_gnt) begin
      resp_owner <= OWN_INST;
    end else if (data_gnt && (data_wen == 4'b0000)) begin
      resp_owner <= OWN_DATA;
    end else begin
      resp_owner <= OWN_NONE;
    end
  end

  assign inst_rvalid = (resp_owner == OWN_INST);
  assign data_rvalid = (resp_owner == OWN_DATA);
  assign inst_rdata  = inst_rvalid ? sram_rdata : '0;
  assign data_rdata  = data_rvalid ? sram_rdata : '0;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] inst_wait;

  // Counts consecutive denied fetch cycles; once it reaches the limit the
  // next contended cycle goes to fetch, which then clears the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_wait <= 4'd0;
    end else if (!inst_req || inst_gnt) begin
      inst_wait <= 4'd0;
    end else if (inst_wait != WAIT_LIMIT) begin
      inst_wait <= inst_wait + 4'd1;
    end
  end

  assign force_inst = (inst_wait == WAIT_LIMIT);
`else
  assign force_inst = 1'b0;
`endif

endmodule
